// File: rtl/sr_mod_counter.sv
// Parametrised up/down modulo counter whose state lives in SR flip-flops.
// Excitation per bit: s = next & ~q, r = ~next & q, so s and r are never both high.
module sr_ff (
  input  logic clk,
  input  logic reset,
  input  logic s,
  input  logic r,
  output logic q
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= 1'b0;
    end else begin
      assert (!(s && r)) else $error("sr_ff: s and r asserted together");
      if (s)      q <= 1'b1;
      else if (r) q <= 1'b0;
    end
  end
endmodule

module sr_mod_counter #(
  parameter int WIDTH    = 3,
  parameter int MODULUS  = 8,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);
  generate
    if (WIDTH < 1 || WIDTH > 16 || MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_param
      $error("sr_mod_counter: illegal WIDTH/MODULUS combination");
    end
  endgenerate

  localparam logic [WIDTH:0] MAXV = (WIDTH+1)'(MODULUS - 1);

  // q holds the count bits plus the ovf flag in the MSB; all are SR flip-flops
  logic [WIDTH:0] q, nxt_q, s, r;
  logic [WIDTH:0] cnt_x, lv_x, nxt_x;
  logic           at_max, at_zero;
  logic           unused_msb;

  assign cnt_x   = {1'b0, q[WIDTH-1:0]};
  assign lv_x    = {1'b0, load_val};
  assign at_max  = (cnt_x == MAXV);
  assign at_zero = (cnt_x == '0);

  always_comb begin
    nxt_x = cnt_x;
    if (load) begin
      nxt_x = (lv_x > MAXV) ? MAXV : lv_x;
    end else if (en) begin
      if (up) begin
        if (!at_max)            nxt_x = cnt_x + 1'b1;
        else if (SATURATE == 0) nxt_x = '0;
      end else begin
        if (!at_zero)           nxt_x = cnt_x - 1'b1;
        else if (SATURATE == 0) nxt_x = MAXV;
      end
    end
  end

  // tc flags a boundary attempt this cycle, which is exactly next cycle's ovf
  assign tc         = en & ~load & (up ? at_max : at_zero);
  assign nxt_q      = {tc, nxt_x[WIDTH-1:0]};
  assign unused_msb = nxt_x[WIDTH];

  assign s = nxt_q & ~q;
  assign r = ~nxt_q & q;

  generate
    for (genvar i = 0; i <= WIDTH; i++) begin : g_ff
      sr_ff u_ff (
        .clk   (clk),
        .reset (reset),
        .s     (s[i]),
        .r     (r[i]),
        .q     (q[i])
      );
    end
  endgenerate

  assign count = q[WIDTH-1:0];
  assign ovf   = q[WIDTH];
endmodule

// File: tb/tb_sr_mod_counter.sv
// Bench for sr_mod_counter: three configurations share one stimulus stream and
// are compared against a modular-arithmetic reference model every cycle.
module tb_sr_mod_counter;
  logic       clk = 1'b0;
  logic       reset;
  logic       en, up, load;
  logic [3:0] lv;
  logic [2:0] c0;
  logic [3:0] c1, c2;
  logic [2:0] tc_a, ovf_a;
  logic [3:0] cnt_a [3];

  always #5 clk = ~clk;

  sr_mod_counter u_d0 (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(lv[2:0]),
    .count(c0), .tc(tc_a[0]), .ovf(ovf_a[0]));
  sr_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_d1 (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(lv),
    .count(c1), .tc(tc_a[1]), .ovf(ovf_a[1]));
  sr_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) u_d2 (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(lv),
    .count(c2), .tc(tc_a[2]), .ovf(ovf_a[2]));

  assign cnt_a[0] = {1'b0, c0};
  assign cnt_a[1] = c1;
  assign cnt_a[2] = c2;

  int total = 0;
  int bad   = 0;
  int mods [3] = '{8, 10, 10};
  bit sats [3] = '{1'b0, 1'b0, 1'b1};
  int mc   [3];
  bit mo   [3];

  typedef struct {
    bit en, up, load;
    logic [3:0] lv;
    int exp_cnt;
    bit exp_ovf;
    bit exp_tc;
  } vec_t;
  vec_t tv [10];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_tc(input int k);
    int m = mods[k];
    return en && !load && (up ? (mc[k] == m - 1) : (mc[k] == 0));
  endfunction

  function automatic void model_edge(input int k);
    int m  = mods[k];
    int lvk = (k == 0) ? int'(lv) % 8 : int'(lv);
    bit bnd;
    if (load) begin
      mc[k] = (lvk > m - 1) ? m - 1 : lvk;
      mo[k] = 1'b0;
    end else if (en) begin
      bnd   = up ? (mc[k] == m - 1) : (mc[k] == 0);
      mo[k] = bnd;
      if (!(bnd && sats[k])) mc[k] = up ? (mc[k] + 1) % m : (mc[k] + m - 1) % m;
    end else begin
      mo[k] = 1'b0;
    end
  endfunction

  // Called at a negedge: drive inputs and check the combinational tc.
  task automatic pre(input bit e, input bit u, input bit l, input logic [3:0] v);
    en = e; up = u; load = l; lv = v;
    #1;
    for (int k = 0; k < 3; k++) chk($sformatf("tc_d%0d", k), 16'(tc_a[k]), 16'(model_tc(k)));
  endtask

  // Advance the model, cross one rising edge, check registered outputs.
  task automatic post();
    for (int k = 0; k < 3; k++) model_edge(k);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("cnt_d%0d", k), 16'(cnt_a[k]), 16'(mc[k]));
      chk($sformatf("ovf_d%0d", k), 16'(ovf_a[k]), 16'(mo[k]));
    end
  endtask

  task automatic step(input bit e, input bit u, input bit l, input logic [3:0] v);
    pre(e, u, l, v);
    post();
  endtask

  // Reset pulse raised between edges; outputs must clear before the next edge.
  task automatic mid_reset();
    #2 reset = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_cnt_d%0d", k), 16'(cnt_a[k]), 16'd0);
      chk($sformatf("rst_ovf_d%0d", k), 16'(ovf_a[k]), 16'd0);
      mc[k] = 0;
      mo[k] = 1'b0;
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    tv[0] = '{1, 1, 0, 4'd0, 1, 0, 0};
    tv[1] = '{1, 1, 0, 4'd0, 2, 0, 0};
    tv[2] = '{1, 1, 0, 4'd0, 3, 0, 0};
    tv[3] = '{1, 1, 0, 4'd0, 4, 0, 0};
    tv[4] = '{1, 1, 0, 4'd0, 5, 0, 0};
    tv[5] = '{1, 1, 0, 4'd0, 6, 0, 0};
    tv[6] = '{1, 1, 0, 4'd0, 7, 0, 0};
    tv[7] = '{1, 1, 0, 4'd0, 0, 1, 1};
    tv[8] = '{1, 1, 0, 4'd0, 1, 0, 0};
    tv[9] = '{1, 1, 0, 4'd0, 2, 0, 0};

    reset = 1'b1; en = 1'b0; up = 1'b0; load = 1'b0; lv = '0;
    for (int k = 0; k < 3; k++) begin mc[k] = 0; mo[k] = 1'b0; end
    #9;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("init_cnt_d%0d", k), 16'(cnt_a[k]), 16'd0);
      chk($sformatf("init_ovf_d%0d", k), 16'(ovf_a[k]), 16'd0);
      chk($sformatf("init_tc_d%0d", k), 16'(tc_a[k]), 16'd0);
    end
    @(negedge clk);
    reset = 1'b0;

    // default counter counting up through the wrap
    for (int i = 0; i < 10; i++) begin
      pre(tv[i].en, tv[i].up, tv[i].load, tv[i].lv);
      chk("tbl_tc", 16'(tc_a[0]), 16'(tv[i].exp_tc));
      post();
      chk("tbl_cnt", 16'(c0), 16'(tv[i].exp_cnt));
      chk("tbl_ovf", 16'(ovf_a[0]), 16'(tv[i].exp_ovf));
    end

    // mod-10 counting down from reset
    mid_reset();
    pre(1, 0, 0, 4'd0);
    chk("dn_tc_at0", 16'(tc_a[1]), 16'd1);
    post();
    chk("dn_wrap_cnt", 16'(c1), 16'd9);
    chk("dn_wrap_ovf", 16'(ovf_a[1]), 16'd1);
    chk("dn_sat_cnt", 16'(c2), 16'd0);
    step(1, 0, 0, 4'd0);
    chk("dn_cnt8", 16'(c1), 16'd8);
    chk("dn_ovf_clr", 16'(ovf_a[1]), 16'd0);

    // saturating mod-10: load 8 then hold at 9 with back-to-back ovf
    step(0, 0, 1, 4'd8);
    chk("sat_load8", 16'(c2), 16'd8);
    step(1, 1, 0, 4'd0);
    chk("sat_cnt9", 16'(c2), 16'd9);
    chk("sat_ovf0", 16'(ovf_a[2]), 16'd0);
    step(1, 1, 0, 4'd0);
    chk("sat_hold1", 16'(c2), 16'd9);
    chk("sat_ovf1", 16'(ovf_a[2]), 16'd1);
    step(1, 1, 0, 4'd0);
    chk("sat_hold2", 16'(c2), 16'd9);
    chk("sat_ovf2", 16'(ovf_a[2]), 16'd1);

    // load clamping, and load beating en while at the boundary
    pre(1, 1, 1, 4'd15);
    chk("ld_tc_blocked", 16'(tc_a[2]), 16'd0);
    post();
    chk("clamp_d1", 16'(c1), 16'd9);
    chk("clamp_d2", 16'(c2), 16'd9);
    chk("clamp_d0", 16'(c0), 16'd7);
    chk("ld_ovf_clr", 16'(ovf_a[2]), 16'd0);

    // asynchronous reset in mid-count, then resume from 0
    step(0, 0, 1, 4'd5);
    chk("mid_cnt5", 16'(c1), 16'd5);
    step(1, 1, 0, 4'd0);
    mid_reset();
    step(1, 1, 0, 4'd0);
    chk("resume_d0", 16'(c0), 16'd1);
    chk("resume_d1", 16'(c1), 16'd1);

    // random traffic against the model
    for (int i = 0; i < 1000; i++) begin
      step(($urandom % 4) != 0, $urandom % 2, ($urandom % 8) == 0, 4'($urandom % 16));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
